// File: rtl/beam_sweep_controller.sv
// Steering-angle sequencer for the transmit beamformer: sweeps -ANGLE_MAX_DEG..+ANGLE_MAX_DEG,
// dwelling BURSTS_PER_ANGLE periods per angle and switching only on period boundaries.
module beam_sweep_controller #(
  parameter int PERIOD_DURATION  = 16777216,
  parameter int BURSTS_PER_ANGLE = 4,
  parameter int ANGLE_MAX_DEG    = 60,
  parameter int ANGLE_STEP_DEG   = 5,
  parameter int SIN_WIDTH        = 16
) (
  input  logic                 clk,
  input  logic                 rst_in,
  input  logic                 start_in,
  input  logic                 stop_in,
  input  logic                 continuous_in,
  output logic [SIN_WIDTH-1:0] sin_theta,
  output logic                 sign_bit,
  output logic signed [7:0]    angle_out,
  output logic                 frame_start,
  output logic                 angle_valid,
  output logic                 sweep_done,
  output logic                 busy
);
  localparam int CNT_W = (PERIOD_DURATION > 1) ? $clog2(PERIOD_DURATION) : 1;
  localparam int BST_W = (BURSTS_PER_ANGLE > 1) ? $clog2(BURSTS_PER_ANGLE) : 1;
  localparam logic [CNT_W-1:0] PCNT_LAST = CNT_W'(PERIOD_DURATION - 1);
  localparam logic [BST_W-1:0] BCNT_LAST = BST_W'(BURSTS_PER_ANGLE - 1);
  localparam logic signed [7:0] ANGLE_FIRST = 8'(-ANGLE_MAX_DEG);
  localparam logic signed [8:0] ANGLE_MAX9  = 9'(ANGLE_MAX_DEG);
  localparam logic signed [8:0] ANGLE_STEP9 = 9'(ANGLE_STEP_DEG);
  localparam int RND_SH = (SIN_WIDTH < 16) ? 16 - SIN_WIDTH : 0;
  localparam int LFT_SH = (SIN_WIDTH > 16) ? SIN_WIDTH - 16 : 0;
  localparam logic [31:0] RND_HALF = 32'((1 << RND_SH) >> 1);

  // round(sin(d) * 2^15) for d = 0..90
  localparam logic [15:0] SIN_Q15 [91] = '{
    16'd0,     16'd572,   16'd1144,  16'd1715,  16'd2286,  16'd2856,  16'd3425,  16'd3993,  16'd4560,  16'd5126,
    16'd5690,  16'd6252,  16'd6813,  16'd7371,  16'd7927,  16'd8481,  16'd9032,  16'd9580,  16'd10126, 16'd10668,
    16'd11207, 16'd11743, 16'd12275, 16'd12803, 16'd13328, 16'd13848, 16'd14365, 16'd14876, 16'd15384, 16'd15886,
    16'd16384, 16'd16877, 16'd17364, 16'd17847, 16'd18324, 16'd18795, 16'd19261, 16'd19720, 16'd20174, 16'd20622,
    16'd21063, 16'd21498, 16'd21926, 16'd22348, 16'd22763, 16'd23170, 16'd23571, 16'd23965, 16'd24351, 16'd24730,
    16'd25102, 16'd25466, 16'd25822, 16'd26170, 16'd26510, 16'd26842, 16'd27166, 16'd27482, 16'd27789, 16'd28088,
    16'd28378, 16'd28660, 16'd28932, 16'd29197, 16'd29452, 16'd29698, 16'd29935, 16'd30163, 16'd30382, 16'd30592,
    16'd30792, 16'd30983, 16'd31164, 16'd31336, 16'd31499, 16'd31651, 16'd31795, 16'd31928, 16'd32052, 16'd32166,
    16'd32270, 16'd32365, 16'd32449, 16'd32524, 16'd32588, 16'd32643, 16'd32688, 16'd32723, 16'd32748, 16'd32763,
    16'd32768
  };

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  pcnt, pcnt_n;
  logic [BST_W-1:0]  bcnt, bcnt_n;
  logic signed [7:0] angle_n;
  logic signed [8:0] angle_inc;
  logic              frame_n, valid_n, done_n, busy_n;

  function automatic logic [6:0] abs_angle(input logic signed [7:0] a);
    return 7'((a < 0) ? -a : a);
  endfunction

  // Q1.15 table rescaled to SIN_WIDTH with round-half-up when narrowing
  function automatic logic [SIN_WIDTH-1:0] sin_lookup(input logic [6:0] d);
    logic [31:0] t;
    t = (d > 7'd90) ? 32'd0 : {16'd0, SIN_Q15[d]};
    t = ((t + RND_HALF) >> RND_SH) << LFT_SH;
    return SIN_WIDTH'(t);
  endfunction

  // 9-bit sum so the end-of-sweep test cannot wrap near +90 degrees
  assign angle_inc = {angle_out[7], angle_out} + ANGLE_STEP9;

  always_comb begin
    state_n = state;
    pcnt_n  = pcnt;
    bcnt_n  = bcnt;
    angle_n = angle_out;
    frame_n = 1'b0;
    valid_n = 1'b0;
    done_n  = 1'b0;
    busy_n  = busy;
    case (state)
      IDLE: begin
        pcnt_n  = '0;
        bcnt_n  = '0;
        angle_n = '0;
        busy_n  = 1'b0;
        if (start_in && !stop_in) begin
          state_n = SWEEP;
          angle_n = ANGLE_FIRST;
          frame_n = 1'b1;
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      SWEEP: begin
        busy_n = 1'b1;
        if (stop_in) begin
          state_n = IDLE;
          pcnt_n  = '0;
          bcnt_n  = '0;
          angle_n = '0;
          busy_n  = 1'b0;
        end else if (pcnt == PCNT_LAST) begin
          pcnt_n  = '0;
          frame_n = 1'b1;
          if (bcnt == BCNT_LAST) begin
            bcnt_n = '0;
            if (angle_inc > ANGLE_MAX9) begin
              done_n = 1'b1;
              if (continuous_in) begin
                angle_n = ANGLE_FIRST;
                valid_n = 1'b1;
              end else begin
                state_n = IDLE;
                angle_n = '0;
                frame_n = 1'b0;
                busy_n  = 1'b0;
              end
            end else begin
              angle_n = angle_inc[7:0];
              valid_n = 1'b1;
            end
          end else begin
            bcnt_n = bcnt + 1'b1;
          end
        end else begin
          pcnt_n = pcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_in) begin
      state       <= IDLE;
      pcnt        <= '0;
      bcnt        <= '0;
      angle_out   <= '0;
      sin_theta   <= '0;
      sign_bit    <= 1'b0;
      frame_start <= 1'b0;
      angle_valid <= 1'b0;
      sweep_done  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      pcnt        <= pcnt_n;
      bcnt        <= bcnt_n;
      angle_out   <= angle_n;
      sin_theta   <= sin_lookup(abs_angle(angle_n));
      sign_bit    <= angle_n[7];
      frame_start <= frame_n;
      angle_valid <= valid_n;
      sweep_done  <= done_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_beam_sweep_controller.sv
// Bench for beam_sweep_controller: several parameterisations share one stimulus stream and are
// compared every cycle against an elapsed-time model of the sweep.
module tb_beam_sweep_controller;
  localparam int N = 5;
  localparam int PA [N] = '{8, 4, 4, 5, 3};
  localparam int BA [N] = '{2, 1, 3, 2, 3};
  localparam int MA [N] = '{10, 90, 12, 90, 0};
  localparam int SA [N] = '{5, 30, 5, 170, 5};
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0;
  logic rst_in, start_in, stop_in, continuous_in;
  logic [15:0]       sin_o [N];
  logic              sign_o [N];
  logic signed [7:0] ang_o [N];
  logic              fs_o [N], av_o [N], sd_o [N], bz_o [N];

  int checks = 0;
  int failures = 0;
  bit act [N];
  int el [N];
  bit dn [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    beam_sweep_controller #(
      .PERIOD_DURATION(PA[g]), .BURSTS_PER_ANGLE(BA[g]), .ANGLE_MAX_DEG(MA[g]),
      .ANGLE_STEP_DEG(SA[g]), .SIN_WIDTH(16)
    ) u_dut (
      .clk(clk), .rst_in(rst_in), .start_in(start_in), .stop_in(stop_in),
      .continuous_in(continuous_in), .sin_theta(sin_o[g]), .sign_bit(sign_o[g]),
      .angle_out(ang_o[g]), .frame_start(fs_o[g]), .angle_valid(av_o[g]),
      .sweep_done(sd_o[g]), .busy(bz_o[g])
    );
  end

  function automatic int sweep_len(input int i);
    return ((2 * MA[i]) / SA[i] + 1) * BA[i] * PA[i];
  endfunction

  function automatic int ref_sin(input int deg);
    real r;
    r = $sin(deg * PI / 180.0) * 32768.0 + 0.5;
    return int'($floor(r));
  endfunction

  task automatic check(input string tag, input int i, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s u%0d observed=%0d expected=%0d", tag, i, obs, expv);
    end
  endtask

  task automatic model_update();
    for (int i = 0; i < N; i++) begin
      dn[i] = 1'b0;
      if (!rst_in) act[i] = 1'b0;
      else if (act[i]) begin
        if (stop_in) act[i] = 1'b0;
        else begin
          el[i]++;
          if (el[i] == sweep_len(i)) begin
            dn[i] = 1'b1;
            if (continuous_in) el[i] = 0;
            else act[i] = 1'b0;
          end
        end
      end else if (start_in && !stop_in) begin
        act[i] = 1'b1;
        el[i] = 0;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < N; i++) begin
      int a, mag, dwell;
      dwell = BA[i] * PA[i];
      a = act[i] ? (-MA[i] + (el[i] / dwell) * SA[i]) : 0;
      mag = (a < 0) ? -a : a;
      check("angle_out", i, 32'(ang_o[i]), a);
      check("sin_theta", i, 32'(sin_o[i]), ref_sin(mag));
      check("sign_bit", i, 32'(sign_o[i]), 32'(a < 0));
      check("frame_start", i, 32'(fs_o[i]), 32'(act[i] && (el[i] % PA[i] == 0)));
      check("angle_valid", i, 32'(av_o[i]), 32'(act[i] && (el[i] % dwell == 0)));
      check("sweep_done", i, 32'(sd_o[i]), 32'(dn[i]));
      check("busy", i, 32'(bz_o[i]), 32'(act[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  int t0c [5] = '{1, 17, 33, 49, 65};
  int t0a [5] = '{-10, -5, 0, 5, 10};
  int t0s [5] = '{5690, 2856, 0, 2856, 5690};
  int t1a [7] = '{-90, -60, -30, 0, 30, 60, 90};
  int t1s [7] = '{32768, 28378, 16384, 0, 16384, 28378, 32768};

  initial begin
    for (int i = 0; i < N; i++) begin
      act[i] = 1'b0;
      el[i] = 0;
      dn[i] = 1'b0;
    end
    rst_in = 1'b0; start_in = 1'b0; stop_in = 1'b0; continuous_in = 1'b0;

    // reset held with start toggling
    for (int c = 0; c < 3; c++) begin
      start_in = c[0];
      step();
    end
    start_in = 1'b0;
    rst_in = 1'b1;
    step();

    // single sweep with fixed-value spot checks
    start_in = 1'b1;
    for (int c = 1; c <= 85; c++) begin
      step();
      start_in = 1'b0;
      for (int k = 0; k < 5; k++)
        if (c == t0c[k]) begin
          check("dir_angle", 0, 32'(ang_o[0]), t0a[k]);
          check("dir_sin", 0, 32'(sin_o[0]), t0s[k]);
          check("dir_sign", 0, 32'(sign_o[0]), 32'(t0a[k] < 0));
        end
      for (int k = 0; k < 7; k++)
        if (c == 1 + 4 * k) begin
          check("dir_angle90", 1, 32'(ang_o[1]), t1a[k]);
          check("dir_sin90", 1, 32'(sin_o[1]), t1s[k]);
        end
      if (c == 81) begin
        check("dir_done", 0, 32'(sd_o[0]), 1);
        check("dir_busy_end", 0, 32'(bz_o[0]), 0);
      end
    end

    // continuous sweeps, then stop
    continuous_in = 1'b1;
    start_in = 1'b1;
    for (int c = 1; c <= 200; c++) begin
      step();
      start_in = 1'b0;
      if (c == 81) begin
        check("cont_done", 0, 32'(sd_o[0]), 1);
        check("cont_angle", 0, 32'(ang_o[0]), -10);
        check("cont_frame", 0, 32'(fs_o[0]), 1);
        check("cont_busy", 0, 32'(bz_o[0]), 1);
      end
    end
    stop_in = 1'b1;
    step();
    stop_in = 1'b0;
    continuous_in = 1'b0;
    step();

    // start and stop together: stop wins
    start_in = 1'b1;
    stop_in = 1'b1;
    step();
    check("startstop_busy", 0, 32'(bz_o[0]), 0);
    start_in = 1'b0;
    stop_in = 1'b0;
    for (int c = 0; c < 3; c++) step();

    // stop at cycle 40
    start_in = 1'b1;
    for (int c = 1; c <= 50; c++) begin
      step();
      start_in = 1'b0;
      stop_in = (c == 40);
      if (c == 41) begin
        check("stop_busy", 0, 32'(bz_o[0]), 0);
        check("stop_angle", 0, 32'(ang_o[0]), 0);
        check("stop_done", 0, 32'(sd_o[0]), 0);
      end
    end

    // reset at cycle 20
    start_in = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      step();
      start_in = 1'b0;
      rst_in = (c != 20);
      if (c == 21) begin
        check("rst_busy", 0, 32'(bz_o[0]), 0);
        check("rst_angle", 0, 32'(ang_o[0]), 0);
      end
    end
    rst_in = 1'b1;

    // randomized control traffic
    for (int c = 0; c < 1500; c++) begin
      start_in = ($urandom_range(0, 19) == 0);
      stop_in = ($urandom_range(0, 149) == 0);
      rst_in = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 99) == 0) continuous_in = ~continuous_in;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/beam_sweep_controller.md
Name: beam_sweep_controller

Overview:
- Steering-angle sequencer that feeds transmit_beamformer with sin_theta and sign_bit.
- Steps the beam from -ANGLE_MAX_DEG to +ANGLE_MAX_DEG in ANGLE_STEP_DEG increments and holds each angle for BURSTS_PER_ANGLE transmit periods.
- Changes angle only at period boundaries, so per-element delays never change mid-burst.
- Emits frame_start and the current angle so receive/processing logic can tag echoes with the angle they belong to.

Parameters:
PERIOD_DURATION, 16777216, clock cycles per transmit period; must equal the beamformer's PERIOD_DURATION; >= 2
BURSTS_PER_ANGLE, 4, periods dwelt at each angle; >= 1
ANGLE_MAX_DEG, 60, sweep half-range in integer degrees; 0..90
ANGLE_STEP_DEG, 5, sweep increment in degrees; >= 1
SIN_WIDTH, 16, width of sin_theta; Q1.(SIN_WIDTH-1) unsigned magnitude

Ports:
clk  input  1  system clock
rst_in  input  1  synchronous, active-low reset
start_in  input  1  single-cycle request to begin a sweep
stop_in  input  1  abort the sweep and return to idle
continuous_in  input  1  1 = restart the sweep after the last angle; 0 = single sweep
sin_theta  output  SIN_WIDTH  |sin(angle)| to the beamformer
sign_bit  output  1  1 when angle < 0
angle_out  output  8  current angle, signed two's complement degrees
frame_start  output  1  one-cycle pulse on the first cycle of every transmit period
angle_valid  output  1  one-cycle pulse when a new angle is applied
sweep_done  output  1  one-cycle pulse when a sweep completes
busy  output  1  high while sweeping

Behaviour:
- Reset (rst_in=0 at a clk edge): state IDLE; all outputs 0; period and burst counters 0.
- Sine LUT: 91 entries for d = 0..90, value = floor(sin(d deg) * 2^(SIN_WIDTH-1) + 0.5). Entry 90 = 2^(SIN_WIDTH-1) = 32768, which fits in 16 bits unsigned.
- Output mapping: sin_theta = LUT[|angle|]; sign_bit = (angle < 0). Angle 0 gives sign_bit = 0.
- Output timing: sin_theta, sign_bit and angle_out are registered and always update on the same edge.
- IDLE:
  - Outputs are angle 0 / sin 0 / sign 0, with busy = 0.
  - start_in=1 with stop_in=0 at cycle t moves to SWEEP.
  - At t+1: busy=1, angle_out=-ANGLE_MAX_DEG, frame_start=1, angle_valid=1, period counter=0, burst counter=0.
  - If start_in and stop_in are both high, stop wins and the block stays in IDLE.
- SWEEP:
  - The period counter counts 0..PERIOD_DURATION-1 and wraps.
  - On the cycle after the wrap, frame_start=1.
  - On each wrap the burst counter increments. When it would reach BURSTS_PER_ANGLE it resets to 0 and the angle advances by ANGLE_STEP_DEG; angle_valid pulses with the same frame_start.
- End of sweep:
  - The last angle is the largest -ANGLE_MAX_DEG + k*ANGLE_STEP_DEG that is <= ANGLE_MAX_DEG. A non-multiple step therefore never overshoots.
  - When the last angle's final period ends, sweep_done=1 for one cycle.
  - continuous_in=1 at that cycle: in the same cycle angle returns to -ANGLE_MAX_DEG with frame_start=1 and angle_valid=1; busy stays 1.
  - continuous_in=0 at that cycle: return to IDLE. In the same cycle busy=0 and outputs return to angle 0; frame_start=0.
- ANGLE_MAX_DEG=0: a single angle 0 is held for BURSTS_PER_ANGLE periods per sweep.
- stop_in=1 in SWEEP: next cycle is IDLE with idle outputs. No sweep_done is issued and counters clear.
- start_in during SWEEP is ignored.
- Reset asserted mid-sweep behaves exactly as reset from any state.
- Counter width: period counter is clog2(PERIOD_DURATION) bits.
- Arithmetic: the angle is held signed 8-bit. The next-angle comparison uses 9-bit signed arithmetic so it cannot wrap at ANGLE_MAX_DEG=90 with a large step.

Test Plan:
- Reset with rst_in=0 for 3 cycles and start_in toggling -> all outputs 0, busy=0, no pulses.
- PERIOD_DURATION=8, BURSTS_PER_ANGLE=2, ANGLE_MAX_DEG=10, STEP=5, continuous_in=0; start_in at cycle 0:
  - angle_out=-10 at cycle 1, -5 at 17, 0 at 33, 5 at 49, 10 at 65.
  - frame_start every 8 cycles from cycle 1; angle_valid only at 1, 17, 33, 49, 65.
  - sweep_done and busy=0 at cycle 81.
- LUT and sign check, same sweep: angle -10 -> sin_theta=5690, sign_bit=1; -5 -> 2856, sign_bit=1; 0 -> 0, sign_bit=0; 10 -> 5690, sign_bit=0. With ANGLE_MAX_DEG=90, STEP=30: angles -90, -60, -30, 0, 30, 60, 90 -> sin_theta 32768, 28378, 16384, 0, 16384, 28378, 32768.
- continuous_in=1 with the config above -> at cycle 81 sweep_done=1, angle_out=-10, frame_start=1, busy stays 1; the second sweep repeats the same timing offset by 80.
- ANGLE_MAX_DEG=12, STEP=5 -> angles -12, -7, -2, 3, 8, then sweep_done; 13 never appears.
- stop_in at cycle 40 -> cycle 41 IDLE, angle 0, busy 0, no sweep_done. start_in with stop_in at the same cycle -> stays IDLE. Reset at cycle 20 mid-sweep -> IDLE and outputs 0 on the next edge.
